mnist_argmax: RTL and testbench
===============================

# mnist_argmax

Streaming classifier stage directly downstream of the output-layer bias/sum neurons. Accepts the NUM_CLASS neuron scores of one image, one score per accepted beat in class order (class 0 first), tracks the running maximum, and emits the winning class index with its score over a valid/ready handshake. The final stage of the MNIST inference datapath; its result drives the digit readout.

## Interface
- BIT_WIDTH, 8, width of one neuron score (same width as the bias stage output)
- NUM_CLASS, 10, scores per image; legal range 1..256
- IDX_WIDTH, $clog2(NUM_CLASS) with minimum 1, width of the class index (derived, not overridden)

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data holds a valid score
- in_ready  output  1  block accepts a score this cycle
- in_data  input  BIT_WIDTH  neuron score, class order
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_class  output  IDX_WIDTH  index of maximum score
- out_score  output  BIT_WIDTH  maximum score value

## Operation
- States: ACCUM, DONE. Reset state ACCUM.
- Beat = in_valid && in_ready. in_ready = (state == ACCUM).
- ACCUM, beat with cnt == 0: best_score <= in_data, best_idx <= 0 unconditionally.
- ACCUM, beat with cnt > 0: if in_data > best_score (strict), best_score <= in_data, best_idx <= cnt. Ties keep the lower index.
- cnt increments per beat; on beat with cnt == NUM_CLASS-1: cnt <= 0, state <= DONE. Wraps only at NUM_CLASS, never at 2^IDX_WIDTH.
- DONE: out_valid = 1, out_class = best_idx, out_score = best_score, all held stable until out_ready. On out_valid && out_ready: state <= ACCUM.
- in_valid without in_ready (DONE) is ignored; the upstream holds data.
- Comparison is unsigned unless ARGMAX_SIGNED_EN.
- NUM_CLASS == 1: every beat goes directly to DONE with idx 0.
- Reset mid-image: cnt, best_*, state cleared; the partial image is discarded.

## Timing
- Reset values: in_ready 1 (after reset deasserts), out_valid 0, out_class 0, out_score 0; cnt 0, best_idx 0, best_score 0.
- out_valid rises the cycle after the beat carrying the last score (1-cycle latency).
- in_ready rises the cycle after the output handshake; no same-cycle bypass.
- Peak throughput: one image per NUM_CLASS+1 cycles with out_ready held high.
- out_* are registers; no combinational path from in_* or out_ready to out_*. out_ready drives only next state.

## Configuration
- ARGMAX_SIGNED_EN defined: scores are two's complement; the comparison is $signed(in_data) > $signed(best_score). Use this when the upstream emits signed sums.
- Not defined: unsigned comparison, which matches the wrap-around unsigned sums of the bias stage.
- The macro affects only the comparator; ports and timing are identical.

## Structure
- Package mnist_pkg: BIT_WIDTH and NUM_CLASS default constants, shared with the bias/sum stage; the state enum typedef (ACCUM, DONE); the class-index typedef.
- One sub-module, argmax_cmp: a combinational strict-greater compare of BIT_WIDTH operands that holds the ARGMAX_SIGNED_EN conditional, so the block holds only the FSM, counter and registers.

## Test plan
- Reset: assert rst mid-image after 4 beats, then release and stream 0..9 → no output for the partial image; out_class=9, out_score=9 for the new image.
- Basic: scores {3,7,1,200,5,9,0,2,8,4}, out_ready=1 → out_valid one cycle after 10th beat, out_class=3, out_score=200; in_ready high again one cycle later.
- Tie: scores {5,9,9,1,0,0,0,0,0,9} → out_class=1, out_score=9.
- Backpressure: out_ready=0 for 20 cycles after result, in_valid held high → in_ready=0, out_* stable throughout; after out_ready pulses, the next image is accepted from the following cycle.
- Stall: in_valid toggled randomly over scores {0,...,0,255 at class 9} → out_class=9, out_score=255; no beat is lost or duplicated.
- Signed (ARGMAX_SIGNED_EN): scores {8'h80,8'hFF,8'h01,0,...} → out_class=2, out_score=8'h01; same stimulus without the macro → out_class=1, out_score=8'hFF.

Source files
------------

// File: rtl/mnist_pkg.sv
// mnist_pkg
// Shared constants and types for the MNIST output stages (bias/sum and argmax).
//   BIT_WIDTH_DEF   : default neuron score width
//   NUM_CLASS_DEF   : default number of output classes
//   idx_width()     : class-index width for a given class count (minimum 1)
//   argmax_state_t  : argmax FSM state encoding
//   class_idx_t     : class index at the default class count
package mnist_pkg;

  localparam int BIT_WIDTH_DEF = 8;
  localparam int NUM_CLASS_DEF = 10;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CLASS_IDX_WIDTH = idx_width(NUM_CLASS_DEF);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } argmax_state_t;

  typedef logic [CLASS_IDX_WIDTH-1:0] class_idx_t;

endpackage

// File: rtl/mnist_argmax_cmp.sv
// argmax_cmp
// Combinational strict-greater comparator for neuron scores.
//   a, b : operands (BIT_WIDTH)
//   gt   : 1 when a > b
// Macro ARGMAX_SIGNED_EN: when defined, operands are two's complement;
// otherwise the compare is unsigned, matching the wrap-around sums upstream.
module argmax_cmp #(
  parameter int BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic                 gt
);

`ifdef ARGMAX_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
`else
  assign gt = a > b;
`endif

endmodule

// File: rtl/mnist_argmax.sv
// mnist_argmax
// Final MNIST stage: takes NUM_CLASS scores per image in class order, tracks
// the running maximum and presents the winning class and score.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : score handshake, in_data carries one score per beat
//   out_valid/out_ready  : result handshake
//   out_class, out_score : winning index and its score, held until taken
// Macro ARGMAX_SIGNED_EN selects signed comparison (inside argmax_cmp).
//
// state | meaning
// ------+-------------------------------------------------------------
// ACCUM | accepting scores, cnt = index of the next score expected
// DONE  | result presented on out_*, input stalled until out_ready
module mnist_argmax
  import mnist_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int NUM_CLASS = NUM_CLASS_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BIT_WIDTH-1:0]                 in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [idx_width(NUM_CLASS)-1:0]      out_class,
  output logic [BIT_WIDTH-1:0]                 out_score
);

  localparam int IDX_WIDTH = idx_width(NUM_CLASS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

  argmax_state_t          state;
  logic [IDX_WIDTH-1:0]   cnt;
  logic [IDX_WIDTH-1:0]   best_idx;
  logic [BIT_WIDTH-1:0]   best_score;
  logic                   in_gt_best;
  logic                   beat;

  argmax_cmp #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_cmp (
    .a  (in_data),
    .b  (best_score),
    .gt (in_gt_best)
  );

  assign beat = in_valid && in_ready;

  // in_ready and out_valid are kept as registers mirroring the state so that
  // every port of the block is a flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      cnt        <= '0;
      best_idx   <= '0;
      best_score <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (beat) begin
            // The first score of an image always seeds the maximum, so a
            // stale best from the previous image never survives.
            if ((cnt == '0) || in_gt_best) begin
              best_score <= in_data;
              best_idx   <= cnt;
            end
            if (cnt == LAST_IDX) begin
              cnt       <= '0;
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_class = best_idx;
  assign out_score = best_score;

endmodule

// File: tb/tb_mnist_argmax.sv
module tb_mnist_argmax;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_class;
  logic [7:0] out_score;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] img_t [10];

  always #5 clk = ~clk;

  mnist_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "timeout");
  end

  // Streams one image; called and returns at a negedge. On return the last
  // beat has just been clocked in. cycles = clock edges consumed.
  task automatic feed(input img_t s, input bit stall, output int cycles);
    int  i;
    bit  rdy;
    i = 0;
    cycles = 0;
    while (i < 10 && cycles < 300) begin
      in_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = s[i];
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) i++;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    if (i < 10) begin
      checks++; errors++;
      $display("FAIL feed_timeout beats accepted %0d required 10", i);
    end
  endtask

  task automatic test_reset();
    img_t s;
    int   cyc;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_class !== 4'd0) begin errors++; $display("FAIL rst_out_class got %0d want 0", out_class); end
    checks++; if (out_score !== 8'd0) begin errors++; $display("FAIL rst_out_score got %0d want 0", out_score); end
    // partial image, then reset in the middle
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'(50 + 10 * k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_score !== 8'd0 || out_class !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_clear got v=%b c=%0d s=%0d r=%b want v=0 c=0 s=0 r=1",
               out_valid, out_class, out_score, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) s[k] = 8'(k);
    feed(s, 1'b0, cyc);
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd9 || out_score !== 8'd9) begin
      errors++;
      $display("FAIL reset_new_image got v=%b c=%0d s=%0d want v=1 c=9 s=9", out_valid, out_class, out_score);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    img_t s = '{8'd3, 8'd7, 8'd1, 8'd200, 8'd5, 8'd9, 8'd0, 8'd2, 8'd8, 8'd4};
    int   cyc;
    out_ready = 1'b1;
    feed(s, 1'b0, cyc);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
    checks++; if (out_class !== 4'd3) begin errors++; $display("FAIL basic_class got %0d want 3", out_class); end
    checks++; if (out_score !== 8'd200) begin errors++; $display("FAIL basic_score got %0d want 200", out_score); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_tie();
    img_t s1 = '{8'd5, 8'd9, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9};
    img_t s2 = '{default: 8'h42};
    int   cyc;
    out_ready = 1'b1;
    feed(s1, 1'b0, cyc);
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd1 || out_score !== 8'd9) begin
      errors++;
      $display("FAIL tie_lower_idx got v=%b c=%0d s=%0d want v=1 c=1 s=9", out_valid, out_class, out_score);
    end
    feed(s2, 1'b0, cyc);
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd0 || out_score !== 8'h42) begin
      errors++;
      $display("FAIL tie_all_equal got v=%b c=%0d s=%0h want v=1 c=0 s=42", out_valid, out_class, out_score);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    img_t s1 = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd250, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};
    img_t s2 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    int   cyc;
    out_ready = 1'b0;
    feed(s1, 1'b0, cyc);
    in_valid = 1'b1; in_data = 8'h77;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== 4'd4 || out_score !== 8'd250) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got r=%b v=%b c=%0d s=%0d want r=0 v=1 c=4 s=250",
                 k, in_ready, out_valid, out_class, out_score);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
    feed(s2, 1'b0, cyc);
    checks++;
    if (cyc !== 10) begin errors++; $display("FAIL bp_next_accept cycles got %0d want 10", cyc); end
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd9 || out_score !== 8'd10) begin
      errors++;
      $display("FAIL bp_next_result got v=%b c=%0d s=%0d want v=1 c=9 s=10", out_valid, out_class, out_score);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall();
    img_t s = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255};
    int   cyc;
    out_ready = 1'b1;
    feed(s, 1'b1, cyc);
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd9 || out_score !== 8'd255) begin
      errors++;
      $display("FAIL stall_result got v=%b c=%0d s=%0d want v=1 c=9 s=255", out_valid, out_class, out_score);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    img_t a = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    img_t b = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd77, 8'd1};
    int   cyc;
    out_ready = 1'b1;
    feed(a, 1'b0, cyc);
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd0 || out_score !== 8'd9) begin
      errors++;
      $display("FAIL b2b_first got v=%b c=%0d s=%0d want v=1 c=0 s=9", out_valid, out_class, out_score);
    end
    feed(b, 1'b0, cyc);
    checks++;
    if (cyc !== 11) begin errors++; $display("FAIL b2b_period cycles got %0d want 11", cyc); end
    checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd8 || out_score !== 8'd77) begin
      errors++;
      $display("FAIL b2b_second got v=%b c=%0d s=%0d want v=1 c=8 s=77", out_valid, out_class, out_score);
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    img_t s = '{8'h80, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    int   cyc;
    logic [3:0] exp_c;
    logic [7:0] exp_s;
`ifdef ARGMAX_SIGNED_EN
    exp_c = 4'd2; exp_s = 8'h01;
`else
    exp_c = 4'd1; exp_s = 8'hFF;
`endif
    out_ready = 1'b1;
    feed(s, 1'b0, cyc);
    checks++;
    if (out_valid !== 1'b1 || out_class !== exp_c || out_score !== exp_s) begin
      errors++;
      $display("FAIL sign_compare got v=%b c=%0d s=%0h want v=1 c=%0d s=%0h",
               out_valid, out_class, out_score, exp_c, exp_s);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_backpressure();
    test_stall();
    test_back_to_back();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
